matmul_wb_collector: RTL and testbench

//  Receiving end of the matmul unit result path. Captures the NROWS result rows that
//  the systolic matmul streams out on c_data, then writes them back to the vector

---
 rtl/matmul_wb_collector_pkg.sv | 20 ++
 rtl/matmul_wb_collector_row_buf.sv | 31 +++
 rtl/matmul_wb_collector.sv | 140 ++++++++++++++
 tb/tb_matmul_wb_collector.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_wb_collector_pkg.sv
// Shared types and sizes for the matmul result collector.
// Matrix geometry defaults and the collector FSM encoding.
package matmul_wb_collector_pkg;

  localparam int MM_NROWS  = 8;
  localparam int MM_DWIDTH = 8;
  localparam int MM_REGIDW = 10;
  localparam int MM_LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } mm_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_wb_collector_row_buf.sv
// Row store for one result matrix.
// One synchronous write port, one asynchronous read port.
module matmul_row_buf #(
  parameter int NROWS = 8,
  parameter int W     = 64,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [NROWS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NROWS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/matmul_wb_collector.sv
// Collects streamed matmul result rows, then writes them
// back to the VRF one row per accepted cycle.
module matmul_wb_collector
  import matmul_wb_collector_pkg::*;
#(
  parameter int NROWS  = MM_NROWS,
  parameter int DWIDTH = MM_DWIDTH,
  parameter int REGIDW = MM_REGIDW,
  parameter int LANES  = MM_LANES
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    squash,
  input  logic [REGIDW-1:0]       in_dst,
  input  logic                    in_dst_we,
  input  logic [LANES-1:0]        in_vmask,
  input  logic                    c_valid,
  input  logic [NROWS*DWIDTH-1:0] c_data,
  output logic                    stall,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [REGIDW-1:0]       wb_dst,
  output logic [NROWS*DWIDTH-1:0] wb_data,
  output logic [LANES-1:0]        wb_mask,
  output logic                    err_overrun
);

  localparam int CW = idx_w(NROWS);
  localparam int RW = NROWS * DWIDTH;
  localparam logic [CW-1:0] LAST = CW'(NROWS - 1);

  mm_state_e         state_q, state_d;
  logic [CW-1:0]     rcnt_q, rcnt_d;
  logic [CW-1:0]     dcnt_q, dcnt_d;
  logic [REGIDW-1:0] dst_q, dst_d;
  logic              we_q, we_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic              err_q, err_d;

  logic          buf_we;
  logic [RW-1:0] buf_rdata;
  logic          drain;

  assign drain = (state_q == ST_DRAIN);

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    dcnt_d  = dcnt_q;
    dst_d   = dst_q;
    we_d    = we_q;
    mask_d  = mask_q;
    err_d   = err_q;
    buf_we  = 1'b0;
    if (squash) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
      dcnt_d  = '0;
    end else begin
      if (start && state_q != ST_IDLE) err_d = 1'b1;
      if (c_valid && state_q != ST_COLLECT) err_d = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            dst_d   = in_dst;
            we_d    = in_dst_we;
            mask_d  = in_vmask;
            rcnt_d  = '0;
            state_d = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (c_valid) begin
            buf_we = 1'b1;
            rcnt_d = rcnt_q + CW'(1);
            if (rcnt_q == LAST) begin
              rcnt_d  = '0;
              dcnt_d  = '0;
              state_d = we_q ? ST_DRAIN : ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (wb_ready) begin
            dcnt_d = dcnt_q + CW'(1);
            if (dcnt_q == LAST) begin
              dcnt_d  = '0;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      dcnt_q  <= '0;
      dst_q   <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      dcnt_q  <= dcnt_d;
      dst_q   <= dst_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  matmul_row_buf #(
    .NROWS (NROWS),
    .W     (RW),
    .AW    (CW)
  ) u_row_buf (
    .clk    (clk),
    .resetn (resetn),
    .we     (buf_we),
    .waddr  (rcnt_q),
    .wdata  (c_data),
    .raddr  (dcnt_q),
    .rdata  (buf_rdata)
  );

  // Writeback fields read as zero outside DRAIN.
  assign stall       = (state_q != ST_IDLE);
  assign wb_valid    = drain;
  assign wb_dst      = drain ? dst_q + REGIDW'(dcnt_q) : '0;
  assign wb_data     = drain ? buf_rdata : '0;
  assign wb_mask     = drain ? mask_q : '0;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_matmul_wb_collector.sv
// Scoreboard bench for matmul_wb_collector.
// Expected writebacks are queued as rows are streamed in.
module tb_matmul_wb_collector;
  import matmul_wb_collector_pkg::*;

  typedef struct packed {
    logic [9:0]  dst;
    logic [63:0] data;
    logic [3:0]  mask;
  } wb_t;

  logic        clk = 0;
  logic        resetn = 0;
  logic        start = 0;
  logic        squash = 0;
  logic [9:0]  in_dst = '0;
  logic        in_dst_we = 0;
  logic [3:0]  in_vmask = '0;
  logic        c_valid = 0;
  logic [63:0] c_data = '0;
  logic        stall;
  logic        wb_valid;
  logic        wb_ready = 1;
  logic [9:0]  wb_dst;
  logic [63:0] wb_data;
  logic [3:0]  wb_mask;
  logic        err_overrun;

  wb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  matmul_wb_collector dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .squash      (squash),
    .in_dst      (in_dst),
    .in_dst_we   (in_dst_we),
    .in_vmask    (in_vmask),
    .c_valid     (c_valid),
    .c_data      (c_data),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_dst      (wb_dst),
    .wb_data     (wb_data),
    .wb_mask     (wb_mask),
    .err_overrun (err_overrun)
  );

  task automatic collect_rows(input logic [9:0] base,
                              input logic we,
                              input logic [3:0] m);
    wb_t e;
    start = 1; in_dst = base; in_dst_we = we; in_vmask = m;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 8; i++) begin
      c_valid = 1;
      c_data = {$urandom, $urandom};
      e.dst = base + 10'(i);
      e.data = c_data;
      e.mask = m;
      if (we) sb.push_back(e);
      @(posedge clk); #1;
    end
    c_valid = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({stall, wb_valid, wb_dst, wb_data, wb_mask, err_overrun} !== '0) begin
      n_bad++;
      $display("FAIL reset: got st=%b v=%b dst=%h d=%h m=%h err=%b want all 0",
               stall, wb_valid, wb_dst, wb_data, wb_mask, err_overrun);
    end
    @(posedge clk); #1;
    resetn = 1;
  endtask

  task automatic test_basic(input logic [9:0] base, input logic [3:0] m);
    wb_t e;
    sb.delete();
    wb_ready = 1;
    collect_rows(base, 1'b1, m);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (wb_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL basic_valid[%0d]: got %b want 1", i, wb_valid);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if ({wb_dst, wb_data, wb_mask} !== e) begin
          n_bad++;
          $display("FAIL basic_wb[%0d]: got %h/%h/%h want %h/%h/%h",
                   i, wb_dst, wb_data, wb_mask, e.dst, e.data, e.mask);
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if ({stall, wb_valid} !== 2'b00 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL basic_end: got st=%b v=%b q=%0d want 0 0 0",
               stall, wb_valid, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    wb_t e;
    wb_t held;
    logic held_v;
    int got;
    sb.delete();
    got = 0;
    held_v = 0;
    wb_ready = 1;
    collect_rows(10'h040, 1'b1, 4'h5);
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      if (wb_valid) begin
        if (held_v) begin
          n_cmp++;
          if ({wb_dst, wb_data, wb_mask} !== held) begin
            n_bad++;
            $display("FAIL bp_hold: got %h/%h/%h want %h/%h/%h",
                     wb_dst, wb_data, wb_mask, held.dst, held.data, held.mask);
          end
        end
        if (wb_ready) begin
          e = sb.pop_front();
          n_cmp++;
          if ({wb_dst, wb_data, wb_mask} !== e) begin
            n_bad++;
            $display("FAIL bp_wb[%0d]: got %h/%h/%h want %h/%h/%h",
                     got, wb_dst, wb_data, wb_mask, e.dst, e.data, e.mask);
          end
          got++;
          held_v = 0;
        end else begin
          held = {wb_dst, wb_data, wb_mask};
          held_v = 1;
        end
      end
      @(posedge clk); #1;
      wb_ready = ~wb_ready;
    end
    wb_ready = 1;
    @(negedge clk);
    n_cmp++;
    if (got != 8 || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_count: got %0d writes st=%b want 8 writes st=0",
               got, stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_no_we;
    int seen;
    sb.delete();
    seen = 0;
    collect_rows(10'h080, 1'b0, 4'hF);
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL nowe_stall: got %b want 0", stall);
    end
    for (int c = 0; c < 10; c++) begin
      if (wb_valid) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL nowe_wb: got %0d valid cycles want 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_squash;
    int seen;
    seen = 0;
    start = 1; in_dst = 10'h100; in_dst_we = 1; in_vmask = 4'hF;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 3; i++) begin
      c_valid = 1; c_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL sq_busy: got %b want 1", stall);
    end
    squash = 1;
    @(posedge clk); #1;
    squash = 0; c_valid = 0;
    @(negedge clk);
    n_cmp++;
    if ({stall, wb_valid, err_overrun} !== 3'b000) begin
      n_bad++;
      $display("FAIL sq_idle: got st=%b v=%b err=%b want 0 0 0",
               stall, wb_valid, err_overrun);
    end
    for (int c = 0; c < 10; c++) begin
      if (wb_valid) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL sq_nowb: got %0d valid cycles want 0", seen);
    end
    @(posedge clk); #1;
    start = 1; squash = 1;
    @(posedge clk); #1;
    start = 0; squash = 0;
    @(negedge clk);
    n_cmp++;
    if ({stall, err_overrun} !== 2'b00) begin
      n_bad++;
      $display("FAIL sq_start: got st=%b err=%b want 0 0", stall, err_overrun);
    end
    @(posedge clk); #1;
    test_basic(10'h020, 4'h3);
  endtask

  task automatic test_overrun;
    wb_t e;
    sb.delete();
    wb_ready = 1;
    collect_rows(10'h200, 1'b1, 4'h9);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        start = 1; in_dst = 10'h300; in_dst_we = 1; in_vmask = 4'h1;
      end
      @(negedge clk);
      n_cmp++;
      if (wb_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL ov_valid[%0d]: got %b want 1", i, wb_valid);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if ({wb_dst, wb_data, wb_mask} !== e) begin
          n_bad++;
          $display("FAIL ov_wb[%0d]: got %h/%h/%h want %h/%h/%h",
                   i, wb_dst, wb_data, wb_mask, e.dst, e.data, e.mask);
        end
      end
      @(posedge clk); #1;
      start = 0;
    end
    @(negedge clk);
    n_cmp++;
    if ({stall, err_overrun} !== 2'b01) begin
      n_bad++;
      $display("FAIL ov_start: got st=%b err=%b want 0 1", stall, err_overrun);
    end
    @(posedge clk); #1;
    resetn = 0;
    #2;
    n_cmp++;
    if ({stall, err_overrun} !== 2'b00) begin
      n_bad++;
      $display("FAIL ov_reset: got st=%b err=%b want 0 0", stall, err_overrun);
    end
    @(posedge clk); #1;
    resetn = 1;
    c_valid = 1; c_data = 64'hDEAD;
    @(posedge clk); #1;
    c_valid = 0;
    @(negedge clk);
    n_cmp++;
    if ({stall, wb_valid, err_overrun} !== 3'b001) begin
      n_bad++;
      $display("FAIL ov_idle: got st=%b v=%b err=%b want 0 0 1",
               stall, wb_valid, err_overrun);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err_overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL ov_sticky: got %b want 1", err_overrun);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic(10'h010, 4'hF);
    test_backpressure();
    test_basic(10'h3FE, 4'h0);
    test_no_we();
    test_squash();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
